// File: rtl/dtree_seq_eval_if.sv
// Handshake and configuration bundle for dtree_seq_eval.
// The master side drives features, the result ready and node-table writes. The slave side is the classifier.
interface dtree_seq_eval_if #(
   parameter int N_FEAT  = 5,
   parameter int FEAT_W  = 8,
   parameter int N_NODES = 64,
   parameter int CLASS_W = 1
);
   localparam int ADDR_W = (N_NODES > 1) ? $clog2(N_NODES) : 1;
   localparam int FIDX_W = (N_FEAT > 1) ? $clog2(N_FEAT) : 1;
   localparam int NODE_W = 1 + FIDX_W + FEAT_W + 2*ADDR_W;

   logic                     in_valid;
   logic                     in_ready;
   logic [N_FEAT*FEAT_W-1:0] in_feats;
   logic                     out_valid;
   logic                     out_ready;
   logic [CLASS_W-1:0]       out_class;
   logic                     out_err;
   logic                     cfg_we;
   logic [ADDR_W-1:0]        cfg_addr;
   logic [NODE_W-1:0]        cfg_data;
   logic                     cfg_err;

   modport master (
      output in_valid, in_feats, out_ready, cfg_we, cfg_addr, cfg_data,
      input  in_ready, out_valid, out_class, out_err, cfg_err
   );

   modport slave (
      input  in_valid, in_feats, out_ready, cfg_we, cfg_addr, cfg_data,
      output in_ready, out_valid, out_class, out_err, cfg_err
   );
endinterface

// File: rtl/dtree_seq_eval.sv
// Table-driven decision-tree classifier. It walks one tree level per clock from a loadable node table.
// Optional DTREE_STATS_EN adds saturating counters of accepted results and of accepted error results.
module dtree_seq_eval #(
   parameter int N_FEAT    = 5,
   parameter int FEAT_W    = 8,
   parameter int N_NODES   = 64,
   parameter int CLASS_W   = 1,
   parameter int MAX_DEPTH = 16
) (
   input  logic                clk,
   input  logic                rst,
   dtree_seq_eval_if.slave     bus
`ifdef DTREE_STATS_EN
   ,
   output logic [15:0]         stat_total,
   output logic [15:0]         stat_err
`endif
);
   localparam int ADDR_W  = (N_NODES > 1) ? $clog2(N_NODES) : 1;
   localparam int FIDX_W  = (N_FEAT > 1) ? $clog2(N_FEAT) : 1;
   localparam int NODE_W  = 1 + FIDX_W + FEAT_W + 2*ADDR_W;
   localparam int DEPTH_W = (MAX_DEPTH > 1) ? $clog2(MAX_DEPTH) : 1;

   typedef enum logic [1:0] {IDLE, WALK, DONE} state_t;

   state_t                   state_reg;
   logic [NODE_W-1:0]        table_mem [N_NODES];
   logic [N_FEAT*FEAT_W-1:0] feats_reg;
   logic [FEAT_W-1:0]        feat_arr [N_FEAT];
   logic [ADDR_W-1:0]        node_ptr_reg;
   logic [DEPTH_W-1:0]       depth_reg;
   logic                     in_ready_reg;
   logic                     out_valid_reg;
   logic [CLASS_W-1:0]       out_class_reg;
   logic                     out_err_reg;
   logic                     cfg_err_reg;

   logic [NODE_W-1:0]        node_word;
   logic                     is_leaf;
   logic [FIDX_W-1:0]        feat_idx;
   logic [FEAT_W-1:0]        thr;
   logic [ADDR_W-1:0]        left;
   logic [ADDR_W-1:0]        right;
   logic [FEAT_W-1:0]        sel_feat;
   logic                     addr_ok;
   logic                     ptr_ok;
   logic                     feat_ok;
   logic                     wr_en;
   logic                     abort;

   genvar gi;

   for (gi = 0; gi < N_FEAT; gi++) begin : g_feat
      assign feat_arr[gi] = feats_reg[gi*FEAT_W +: FEAT_W];
   end

   // Range checks collapse to constants when the index space is exactly filled.
   if (N_NODES == (1 << ADDR_W)) begin : g_addr_full
      assign addr_ok = 1'b1;
      assign ptr_ok  = 1'b1;
   end else begin : g_addr_part
      assign addr_ok = (32'(bus.cfg_addr) < N_NODES);
      assign ptr_ok  = (32'(node_ptr_reg) < N_NODES);
   end

   if (N_FEAT == (1 << FIDX_W)) begin : g_fidx_full
      assign feat_ok = 1'b1;
   end else begin : g_fidx_part
      assign feat_ok = (32'(feat_idx) < N_FEAT);
   end

   assign node_word = ptr_ok ? table_mem[node_ptr_reg] : '0;
   assign is_leaf   = node_word[NODE_W-1];
   assign feat_idx  = node_word[NODE_W-2 -: FIDX_W];
   assign thr       = node_word[2*ADDR_W +: FEAT_W];
   assign left      = node_word[ADDR_W +: ADDR_W];
   assign right     = node_word[0 +: ADDR_W];

   always_comb begin
      sel_feat = '0;
      for (int i = 0; i < N_FEAT; i++) begin
         if (feat_idx == FIDX_W'(i)) sel_feat = feat_arr[i];
      end
   end

   assign abort = !ptr_ok || !feat_ok || (depth_reg == DEPTH_W'(MAX_DEPTH-1));
   assign wr_en = bus.cfg_we && (state_reg == IDLE) && addr_ok;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < N_NODES; i++) table_mem[i] <= '0;
      end else if (wr_en) begin
         table_mem[bus.cfg_addr] <= bus.cfg_data;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg     <= IDLE;
         in_ready_reg  <= 1'b1;
         out_valid_reg <= 1'b0;
         out_class_reg <= '0;
         out_err_reg   <= 1'b0;
         cfg_err_reg   <= 1'b0;
         node_ptr_reg  <= '0;
         depth_reg     <= '0;
         feats_reg     <= '0;
      end else begin
         cfg_err_reg <= bus.cfg_we && ((state_reg != IDLE) || !addr_ok);
         case (state_reg)
            IDLE: begin
               if (bus.in_valid) begin
                  feats_reg    <= bus.in_feats;
                  node_ptr_reg <= '0;
                  depth_reg    <= '0;
                  in_ready_reg <= 1'b0;
                  state_reg    <= WALK;
               end
            end
            WALK: begin
               // A bad pointer makes the node word meaningless, so the leaf flag is not trusted then.
               if (ptr_ok && is_leaf) begin
                  out_class_reg <= thr[CLASS_W-1:0];
                  out_err_reg   <= 1'b0;
                  out_valid_reg <= 1'b1;
                  state_reg     <= DONE;
               end else if (abort) begin
                  out_class_reg <= '0;
                  out_err_reg   <= 1'b1;
                  out_valid_reg <= 1'b1;
                  state_reg     <= DONE;
               end else begin
                  node_ptr_reg <= (sel_feat <= thr) ? left : right;
                  depth_reg    <= depth_reg + 1'b1;
               end
            end
            DONE: begin
               if (bus.out_ready) begin
                  out_valid_reg <= 1'b0;
                  in_ready_reg  <= 1'b1;
                  state_reg     <= IDLE;
               end
            end
            default: begin
               state_reg    <= IDLE;
               in_ready_reg <= 1'b1;
            end
         endcase
      end
   end

   assign bus.in_ready  = in_ready_reg;
   assign bus.out_valid = out_valid_reg;
   assign bus.out_class = out_class_reg;
   assign bus.out_err   = out_err_reg;
   assign bus.cfg_err   = cfg_err_reg;

`ifdef DTREE_STATS_EN
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         stat_total <= '0;
         stat_err   <= '0;
      end else if (out_valid_reg && bus.out_ready) begin
         if (stat_total != 16'hFFFF) stat_total <= stat_total + 16'd1;
         if (out_err_reg && (stat_err != 16'hFFFF)) stat_err <= stat_err + 16'd1;
      end
   end
`endif
endmodule

// File: tb/tb_dtree_seq_eval.sv
// Scoreboard bench for dtree_seq_eval. A reference walk over a shadow copy of the node table supplies expectations.
module tb_dtree_seq_eval;
   localparam int N_FEAT    = 5;
   localparam int FEAT_W    = 8;
   localparam int N_NODES   = 64;
   localparam int CLASS_W   = 1;
   localparam int MAX_DEPTH = 16;

   typedef struct {
      int cls;
      int err;
      int lat;
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_cmp = 0;
   int   n_bad = 0;
   int   n_txn = 0;
   exp_t sb[$];
   logic [23:0] tb_tbl [N_NODES];

   always #5 clk = ~clk;

   dtree_seq_eval_if #(.N_FEAT(N_FEAT), .FEAT_W(FEAT_W), .N_NODES(N_NODES), .CLASS_W(CLASS_W)) bus ();

`ifdef DTREE_STATS_EN
   logic [15:0] stat_total;
   logic [15:0] stat_err;
   int acc_total = 0;
   int acc_err   = 0;
   always @(posedge clk or posedge rst) begin
      if (rst) begin
         acc_total = 0;
         acc_err   = 0;
      end else if (bus.out_valid && bus.out_ready) begin
         acc_total = acc_total + 1;
         if (bus.out_err) acc_err = acc_err + 1;
      end
   end
   dtree_seq_eval #(.N_FEAT(N_FEAT), .FEAT_W(FEAT_W), .N_NODES(N_NODES), .CLASS_W(CLASS_W), .MAX_DEPTH(MAX_DEPTH))
      dut (.clk(clk), .rst(rst), .bus(bus), .stat_total(stat_total), .stat_err(stat_err));
`else
   dtree_seq_eval #(.N_FEAT(N_FEAT), .FEAT_W(FEAT_W), .N_NODES(N_NODES), .CLASS_W(CLASS_W), .MAX_DEPTH(MAX_DEPTH))
      dut (.clk(clk), .rst(rst), .bus(bus));
`endif

   task automatic check_val(input string tag, input int obs, input int exp);
      n_cmp++;
      if (obs != exp) begin
         n_bad++;
         $display("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   function automatic logic [23:0] mk_node(input logic leaf, input logic [2:0] fi, input logic [7:0] th,
                                           input logic [5:0] l, input logic [5:0] r);
      return {leaf, fi, th, l, r};
   endfunction

   function automatic logic [39:0] rand_feats();
      logic [39:0] f;
      f[31:0]  = $urandom();
      f[39:32] = 8'($urandom());
      return f;
   endfunction

   // Reference walk: leaf -> class, bad feature or last allowed level -> error; result seen d+2 edges after accept.
   function automatic void model_eval(input logic [39:0] f, output int cls, output int err, output int lat);
      int ptr;
      logic [23:0] nd;
      logic [7:0] fv;
      ptr = 0;
      cls = 0;
      err = 1;
      lat = MAX_DEPTH + 1;
      for (int d = 0; d < MAX_DEPTH; d++) begin
         nd = tb_tbl[ptr];
         if (nd[23]) begin
            cls = int'(nd[12]);
            err = 0;
            lat = d + 2;
            return;
         end
         if (nd[22:20] >= 3'd5 || d == MAX_DEPTH - 1) begin
            cls = 0;
            err = 1;
            lat = d + 2;
            return;
         end
         fv  = f[nd[22:20]*8 +: 8];
         ptr = (fv <= nd[19:12]) ? int'(nd[11:6]) : int'(nd[5:0]);
      end
   endfunction

   task automatic cfg_wr(input int addr, input logic [23:0] data, input int exp_err);
      @(negedge clk);
      bus.cfg_we   = 1'b1;
      bus.cfg_addr = 6'(addr);
      bus.cfg_data = data;
      @(posedge clk);
      @(negedge clk);
      bus.cfg_we = 1'b0;
      check_val("cfg_err", int'(bus.cfg_err), exp_err);
      if (exp_err == 0) tb_tbl[addr] = data;
   endtask

   task automatic start_vec(input logic [39:0] f, input int cls, input int err, input int lat);
      exp_t e;
      @(negedge clk);
      check_val("in_ready_idle", int'(bus.in_ready), 1);
      bus.in_feats = f;
      bus.in_valid = 1'b1;
      e.cls = cls;
      e.err = err;
      e.lat = lat;
      sb.push_back(e);
      @(posedge clk);
   endtask

   task automatic start_model(input logic [39:0] f);
      int c, e, l;
      model_eval(f, c, e, l);
      start_vec(f, c, e, l);
   endtask

   task automatic wait_result(input string tag);
      int cyc;
      exp_t e;
      cyc = 0;
      do begin
         @(negedge clk);
         bus.in_valid = 1'b0;
         bus.cfg_we   = 1'b0;
         cyc++;
      end while (!bus.out_valid && cyc < 60);
      check_val({tag, "_valid"}, int'(bus.out_valid), 1);
      check_val({tag, "_sb"}, sb.size(), 1);
      if (sb.size() > 0) begin
         e = sb.pop_front();
         check_val({tag, "_class"}, int'(bus.out_class), e.cls);
         check_val({tag, "_err"}, int'(bus.out_err), e.err);
         check_val({tag, "_lat"}, cyc, e.lat);
      end
      check_val({tag, "_in_ready_busy"}, int'(bus.in_ready), 0);
      n_txn++;
      $display("txn %0d %s: class=%0d err=%0d latency=%0d", n_txn, tag, bus.out_class, bus.out_err, cyc);
      if (bus.out_ready) begin
         @(negedge clk);
         check_val({tag, "_drop_valid"}, int'(bus.out_valid), 0);
         check_val({tag, "_back_ready"}, int'(bus.in_ready), 1);
      end
   endtask

   initial begin
      logic [39:0] f;
      bus.in_valid  = 1'b0;
      bus.in_feats  = '0;
      bus.out_ready = 1'b1;
      bus.cfg_we    = 1'b0;
      bus.cfg_addr  = '0;
      bus.cfg_data  = '0;
      for (int i = 0; i < N_NODES; i++) tb_tbl[i] = '0;

      repeat (3) @(posedge clk);
      @(negedge clk);
      check_val("rst_in_ready", int'(bus.in_ready), 1);
      check_val("rst_out_valid", int'(bus.out_valid), 0);
      check_val("rst_out_class", int'(bus.out_class), 0);
      check_val("rst_out_err", int'(bus.out_err), 0);
      check_val("rst_cfg_err", int'(bus.cfg_err), 0);
      rst = 1'b0;

      // Cleared table spins on node 0 until the depth abort.
      start_vec(rand_feats(), 0, 1, MAX_DEPTH + 1);
      wait_result("cleared");

      cfg_wr(0, mk_node(1'b1, 3'd0, 8'h01, 6'd0, 6'd0), 0);
      start_vec(rand_feats(), 1, 0, 2);
      wait_result("root_leaf");

      // Root splits on feature 2 at 100; upper threshold bits of leaves are not part of the class.
      cfg_wr(1, mk_node(1'b1, 3'd0, 8'h02, 6'd0, 6'd0), 0);
      cfg_wr(2, mk_node(1'b1, 3'd0, 8'h03, 6'd0, 6'd0), 0);
      cfg_wr(0, mk_node(1'b0, 3'd2, 8'd100, 6'd1, 6'd2), 0);
      f = rand_feats(); f[23:16] = 8'd100; start_vec(f, 0, 0, 3); wait_result("thr_eq");
      f = rand_feats(); f[23:16] = 8'd101; start_vec(f, 1, 0, 3); wait_result("thr_above");
      f = rand_feats(); f[23:16] = 8'd0;   start_vec(f, 0, 0, 3); wait_result("feat_min");
      f = rand_feats(); f[23:16] = 8'd255; start_vec(f, 1, 0, 3); wait_result("feat_max");

      // Third level on feature 4, with a bad feature index on one branch.
      cfg_wr(3, mk_node(1'b1, 3'd0, 8'h11, 6'd0, 6'd0), 0);
      cfg_wr(4, mk_node(1'b0, 3'd7, 8'd0, 6'd0, 6'd0), 0);
      cfg_wr(2, mk_node(1'b0, 3'd4, 8'd50, 6'd3, 6'd4), 0);
      f = 40'd0; f[23:16] = 8'd200; f[39:32] = 8'd50; start_vec(f, 1, 0, 4); wait_result("lvl2_leaf");
      f = 40'd0; f[23:16] = 8'd200; f[39:32] = 8'd51; start_vec(f, 0, 1, 4); wait_result("bad_fidx");
      for (int k = 0; k < 8; k++) begin
         start_model(rand_feats());
         wait_result("rand");
      end

      // Chain of always-left nodes: a leaf at the deepest level still classifies.
      for (int i = 0; i < MAX_DEPTH - 1; i++) cfg_wr(i, mk_node(1'b0, 3'd0, 8'hFF, 6'(i + 1), 6'd0), 0);
      cfg_wr(MAX_DEPTH - 1, mk_node(1'b1, 3'd0, 8'h01, 6'd0, 6'd0), 0);
      start_vec(rand_feats(), 1, 0, MAX_DEPTH + 1);
      wait_result("deep_leaf");
      cfg_wr(MAX_DEPTH - 1, mk_node(1'b0, 3'd0, 8'hFF, 6'd0, 6'd0), 0);
      start_vec(rand_feats(), 0, 1, MAX_DEPTH + 1);
      wait_result("deep_abort");

      // Stalled sink: outputs hold, and a write attempted meanwhile is dropped.
      cfg_wr(0, mk_node(1'b0, 3'd1, 8'd10, 6'd20, 6'd21), 0);
      cfg_wr(20, mk_node(1'b1, 3'd0, 8'h00, 6'd0, 6'd0), 0);
      cfg_wr(21, mk_node(1'b1, 3'd0, 8'h01, 6'd0, 6'd0), 0);
      bus.out_ready = 1'b0;
      f = 40'd0; f[15:8] = 8'd11;
      start_vec(f, 1, 0, 3);
      wait_result("hold");
      for (int k = 0; k < 5; k++) begin
         if (k == 2) begin
            cfg_wr(21, mk_node(1'b1, 3'd0, 8'h00, 6'd0, 6'd0), 1);
            @(negedge clk);
            check_val("cfg_err_pulse", int'(bus.cfg_err), 0);
         end else begin
            @(negedge clk);
         end
         check_val("hold_valid", int'(bus.out_valid), 1);
         check_val("hold_class", int'(bus.out_class), 1);
         check_val("hold_err", int'(bus.out_err), 0);
         check_val("hold_in_ready", int'(bus.in_ready), 0);
      end
      bus.out_ready = 1'b1;
      @(negedge clk);
      check_val("release_valid", int'(bus.out_valid), 0);
      check_val("release_in_ready", int'(bus.in_ready), 1);
      start_vec(f, 1, 0, 3);
      wait_result("table_kept");

      // Write and accept on the same edge: the walk uses the new root.
      @(negedge clk);
      bus.cfg_we   = 1'b1;
      bus.cfg_addr = 6'd0;
      bus.cfg_data = mk_node(1'b1, 3'd0, 8'h00, 6'd0, 6'd0);
      tb_tbl[0]    = bus.cfg_data;
      bus.in_feats = f;
      bus.in_valid = 1'b1;
      sb.push_back('{cls: 0, err: 0, lat: 2});
      @(posedge clk);
      wait_result("wr_and_go");

      // Reset in the middle of a long walk discards it and empties the table.
      cfg_wr(0, mk_node(1'b0, 3'd0, 8'hFF, 6'd1, 6'd1), 0);
      start_model(rand_feats());
      repeat (3) @(negedge clk);
      bus.in_valid = 1'b0;
      rst = 1'b1;
      #1;
      check_val("midrst_in_ready", int'(bus.in_ready), 1);
      check_val("midrst_out_valid", int'(bus.out_valid), 0);
      @(negedge clk);
      check_val("midrst_in_ready_next", int'(bus.in_ready), 1);
      check_val("midrst_out_valid_next", int'(bus.out_valid), 0);
      sb.delete();
      for (int i = 0; i < N_NODES; i++) tb_tbl[i] = '0;
      rst = 1'b0;
      start_vec(rand_feats(), 0, 1, MAX_DEPTH + 1);
      wait_result("after_rst");

`ifdef DTREE_STATS_EN
      cfg_wr(0, mk_node(1'b1, 3'd0, 8'h01, 6'd0, 6'd0), 0);
      for (int k = 0; k < 3; k++) begin
         start_vec(rand_feats(), 1, 0, 2);
         wait_result("stat_good");
      end
      @(negedge clk);
      check_val("stat_total", int'(stat_total), acc_total);
      check_val("stat_err", int'(stat_err), acc_err);
      check_val("stat_total_abs", int'(stat_total), 4);
      check_val("stat_err_abs", int'(stat_err), 1);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
